jtframe_i2s_tx: RTL and testbench



---
 rtl/jtframe_i2s_pkg.sv | 32 +++
 rtl/jtframe_i2s_div.sv | 34 +++
 rtl/jtframe_i2s_tx.sv | 151 +++++++++++++++
 tb/tb_jtframe_i2s_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_i2s_pkg.sv
// Shared constants and slot formatting helpers for the I2S/LJ/TDM serializer.
// Optional attenuation (JTFRAME_I2S_VOL_EN) uses vol_slot.
package jtframe_i2s_pkg;

  localparam int unsigned MODE_I2S = 0;
  localparam int unsigned MODE_LJ  = 1;

  // Sample in the low dw bits; result is MSB-aligned within the low slotw bits.
  function automatic logic [31:0] pad_slot(input logic [31:0] sample, input int unsigned dw,
                                           input int unsigned slotw, input bit signed_in);
    logic [31:0] s;
    s = sample & ((dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1));
    if (!signed_in) s = s ^ (32'd1 << (dw - 1));
    return s << (slotw - dw);
  endfunction

  // Right shift of an already padded slot; pad bits below dw stay zero.
  function automatic logic [31:0] vol_slot(input logic [31:0] slot, input logic [3:0] vol,
                                           input int unsigned dw, input int unsigned slotw,
                                           input bit arith);
    logic        [31:0] t;
    logic signed [31:0] ts;
    logic        [31:0] pad_mask;
    t        = slot << (32 - slotw);
    ts       = $signed(t);
    t        = arith ? $unsigned(ts >>> vol) : (t >> vol);
    t        = t >> (32 - slotw);
    pad_mask = (32'd1 << (slotw - dw)) - 32'd1;
    return t & ~pad_mask;
  endfunction

endpackage

// File: rtl/jtframe_i2s_div.sv
// Bit clock divider: toggles bclk every BDIV clk cycles and flags the clk cycle
// on which bclk will rise or fall.
module jtframe_i2s_div #(
  parameter int unsigned BDIV = 8
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(BDIV);

  logic [CW-1:0] div_q;
  logic          bclk_q;
  logic          wrap;

  assign wrap = (div_q == CW'(BDIV - 1));
  assign rise = wrap & ~bclk_q;
  assign fall = wrap & bclk_q;
  assign bclk = bclk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q <= wrap ? '0 : div_q + 1'b1;
      if (wrap) bclk_q <= ~bclk_q;
    end
  end

endmodule

// File: rtl/jtframe_i2s_tx.sv
// Parametrised PCM serializer (I2S, left-justified, TDM) with one pending buffer.
// Define JTFRAME_I2S_VOL_EN to add the vol attenuation port.
module jtframe_i2s_tx
  import jtframe_i2s_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter int unsigned SLOTW  = 32,
  parameter int unsigned CH     = 2,
  parameter int unsigned BDIV   = 8,
  parameter int unsigned MODE   = 0,
  parameter int unsigned SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH*DW-1:0] snd_in,
  input  logic             snd_valid,
  output logic             snd_ready,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             underrun
`ifdef JTFRAME_I2S_VOL_EN
  ,
  input  logic [3:0]       vol
`endif
);

  localparam int unsigned FW      = CH * SLOTW;
  localparam int unsigned BW      = $clog2(SLOTW);
  localparam int unsigned SCW     = $clog2(CH);
  localparam bit          TDM     = (CH > 2);
  localparam bit          LR_IDLE = (MODE == MODE_I2S) && !TDM;

  logic             rise, fall, load;
  logic [BW-1:0]    bit_q, bit_d;
  logic [SCW-1:0]   slot_q, slot_d;
  logic             arm_q, first_q;
  logic [CH*DW-1:0] pend_q, pend_d, last_q, last_d, raw;
  logic             pend_full_q, pend_full_d;
  logic [FW-1:0]    shift_q, shift_d, frame;
  logic             sdata_q, sdata_d, lrclk_q, lrclk_d, underrun_q, und_d;

  jtframe_i2s_div #(
    .BDIV (BDIV)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .bclk (bclk),
    .rise (rise),
    .fall (fall)
  );

  // arm_q is set on the rise preceding the fall that starts slot 0, bit 0
  assign load      = fall & arm_q;
  assign snd_ready = ~pend_full_q;
  assign sdata     = sdata_q;
  assign lrclk     = lrclk_q;
  assign underrun  = underrun_q;

  always_comb begin
    bit_d  = bit_q;
    slot_d = slot_q;
    if (fall) begin
      if (bit_q == BW'(SLOTW - 1)) begin
        bit_d  = '0;
        slot_d = (slot_q == SCW'(CH - 1)) ? '0 : slot_q + 1'b1;
      end else begin
        bit_d = bit_q + 1'b1;
      end
    end
  end

  always_comb begin
    raw         = last_q;
    last_d      = last_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    und_d       = 1'b0;
    if (load && !first_q) begin
      if (pend_full_q) begin
        raw         = pend_q;
        pend_full_d = 1'b0;
      end else if (snd_valid) begin
        raw = snd_in;
      end else begin
        und_d = 1'b1;
      end
      last_d = raw;
    end else if (snd_valid && !pend_full_q) begin
      pend_d      = snd_in;
      pend_full_d = 1'b1;
    end
  end

  always_comb begin
    logic [31:0] slot;
    frame = '0;
    for (int c = 0; c < CH; c++) begin
      slot = pad_slot(32'(raw[c*DW +: DW]), DW, SLOTW, SIGNED != 0);
`ifdef JTFRAME_I2S_VOL_EN
      slot = vol_slot(slot, vol, DW, SLOTW, SIGNED != 0);
`endif
      frame[FW-1-c*SLOTW -: SLOTW] = slot[SLOTW-1:0];
    end
  end

  // First load after reset keeps the all-zero frame
  always_comb begin
    if (load) shift_d = first_q ? '0 : frame;
    else if (fall) shift_d = {shift_q[FW-2:0], 1'b0};
    else shift_d = shift_q;
    sdata_d = (MODE == MODE_LJ) ? shift_d[FW-1] : shift_q[FW-1];
    if (TDM) begin
      lrclk_d = (MODE == MODE_LJ) ? (bit_d == '0 && slot_d == '0)
                                  : (bit_d == BW'(SLOTW - 1) && slot_d == SCW'(CH - 1));
    end else begin
      lrclk_d = (MODE == MODE_LJ) ? (slot_d == '0) : (slot_d != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q       <= BW'(SLOTW - 1);
      slot_q      <= SCW'(CH - 1);
      arm_q       <= 1'b0;
      first_q     <= 1'b1;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      last_q      <= '0;
      shift_q     <= '0;
      sdata_q     <= 1'b0;
      lrclk_q     <= LR_IDLE;
      underrun_q  <= 1'b0;
    end else begin
      bit_q       <= bit_d;
      slot_q      <= slot_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      last_q      <= last_d;
      shift_q     <= shift_d;
      underrun_q  <= und_d;
      if (rise) arm_q <= (bit_q == BW'(SLOTW - 1)) && (slot_q == SCW'(CH - 1));
      if (load) first_q <= 1'b0;
      if (fall) begin
        sdata_q <= sdata_d;
        lrclk_q <= lrclk_d;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_i2s_tx.sv
// Bench for jtframe_i2s_tx: four instances (LJ stereo, I2S stereo, TDM LJ, TDM I2S offset
// binary) share clock and handshake stimulus; a frame-level model predicts the streams.
module tb_jtframe_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_v = 1'b0;
  logic [31:0] sd = '0;
  logic [63:0] td = '0;
  logic [3:0]  vol_v = '0;
  logic [3:0]  bclk_w, lr_w, sd_w, rdy_w, und_w;

  int total = 0;
  int bad   = 0;
  int c     = 0;

  // frame-level reference model
  bit          pfull, first_m, und_exp;
  logic [31:0] pend_s, last_s, cur_s;
  logic [63:0] pend_t, last_t, cur_t;
  logic [31:0] frames_s[$];
  logic [63:0] frames_t[$];
  logic [3:0]  vols[$];
  bit          zq[$];
  bit          q_d[4][$];
  bit          q_l[4][$];

  always #5 clk = ~clk;

  jtframe_i2s_tx #(.DW(16), .SLOTW(32), .CH(2), .BDIV(8), .MODE(1), .SIGNED(1)) u_lj (
    .clk(clk), .rst(rst), .snd_in(sd), .snd_valid(valid_v), .snd_ready(rdy_w[0]),
    .bclk(bclk_w[0]), .lrclk(lr_w[0]), .sdata(sd_w[0]), .underrun(und_w[0])
`ifdef JTFRAME_I2S_VOL_EN
    , .vol(vol_v)
`endif
  );
  jtframe_i2s_tx #(.DW(16), .SLOTW(32), .CH(2), .BDIV(8), .MODE(0), .SIGNED(1)) u_i2s (
    .clk(clk), .rst(rst), .snd_in(sd), .snd_valid(valid_v), .snd_ready(rdy_w[1]),
    .bclk(bclk_w[1]), .lrclk(lr_w[1]), .sdata(sd_w[1]), .underrun(und_w[1])
`ifdef JTFRAME_I2S_VOL_EN
    , .vol(vol_v)
`endif
  );
  jtframe_i2s_tx #(.DW(16), .SLOTW(16), .CH(4), .BDIV(8), .MODE(1), .SIGNED(1)) u_tdm (
    .clk(clk), .rst(rst), .snd_in(td), .snd_valid(valid_v), .snd_ready(rdy_w[2]),
    .bclk(bclk_w[2]), .lrclk(lr_w[2]), .sdata(sd_w[2]), .underrun(und_w[2])
`ifdef JTFRAME_I2S_VOL_EN
    , .vol(vol_v)
`endif
  );
  jtframe_i2s_tx #(.DW(16), .SLOTW(16), .CH(4), .BDIV(8), .MODE(0), .SIGNED(0)) u_tdmu (
    .clk(clk), .rst(rst), .snd_in(td), .snd_valid(valid_v), .snd_ready(rdy_w[3]),
    .bclk(bclk_w[3]), .lrclk(lr_w[3]), .sdata(sd_w[3]), .underrun(und_w[3])
`ifdef JTFRAME_I2S_VOL_EN
    , .vol(vol_v)
`endif
  );

  always @(posedge bclk_w[0]) begin #1; q_d[0].push_back(sd_w[0]); q_l[0].push_back(lr_w[0]); end
  always @(posedge bclk_w[1]) begin #1; q_d[1].push_back(sd_w[1]); q_l[1].push_back(lr_w[1]); end
  always @(posedge bclk_w[2]) begin #1; q_d[2].push_back(sd_w[2]); q_l[2].push_back(lr_w[2]); end
  always @(posedge bclk_w[3]) begin #1; q_d[3].push_back(sd_w[3]); q_l[3].push_back(lr_w[3]); end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Slot word as it should appear on the wire, MSB-first in the low sw bits.
  function automatic logic [31:0] slot_word(input int ln, input int k, input int s);
    logic [15:0]        smp;
    logic signed [15:0] ss;
    logic [15:0]        r;
    if (zq[k]) return 32'h0;
    smp = (ln < 2) ? frames_s[k][s*16 +: 16] : frames_t[k][s*16 +: 16];
    if (ln == 3) begin
      r = (smp ^ 16'h8000) >> vols[k];
    end else begin
      ss = $signed(smp);
      ss = ss >>> vols[k];
      r  = $unsigned(ss);
    end
    return (ln < 2) ? {r, 16'h0000} : {16'h0000, r};
  endfunction

  function automatic bit lj_bit(input int ln, input int i);
    int          sw, p, s, b;
    logic [31:0] w;
    sw = (ln < 2) ? 32 : 16;
    p  = i % 64;
    s  = p / sw;
    b  = p % sw;
    w  = slot_word(ln, i / 64, s);
    return w[sw-1-b];
  endfunction

  function automatic bit lr_exp(input int ln, input int i);
    int p;
    p = i % 64;
    case (ln)
      0:       return p < 32;
      1:       return p >= 32;
      2:       return p == 0;
      default: return p == 63;
    endcase
  endfunction

  task automatic tick();
    bit ld;
    @(posedge clk);
    c++;
    ld      = (c >= 16) && (((c - 16) % 1024) == 0);
    und_exp = 1'b0;
    if (ld && first_m) begin
      frames_s.push_back('0); frames_t.push_back('0); vols.push_back('0); zq.push_back(1'b1);
      first_m = 1'b0;
      if (valid_v && !pfull) begin pfull = 1'b1; pend_s = sd; pend_t = td; end
    end else if (ld) begin
      if (pfull) begin cur_s = pend_s; cur_t = pend_t; pfull = 1'b0; end
      else if (valid_v) begin cur_s = sd; cur_t = td; end
      else begin cur_s = last_s; cur_t = last_t; und_exp = 1'b1; end
      last_s = cur_s;
      last_t = cur_t;
      frames_s.push_back(cur_s); frames_t.push_back(cur_t); vols.push_back(vol_v);
      zq.push_back(1'b0);
    end else if (valid_v && !pfull) begin
      pfull = 1'b1; pend_s = sd; pend_t = td;
    end
    #1;
    for (int ln = 0; ln < 4; ln++) begin
      chk($sformatf("ready%0d@%0d", ln, c), rdy_w[ln], !pfull);
      chk($sformatf("underrun%0d@%0d", ln, c), und_w[ln], und_exp);
      chk($sformatf("bclk%0d@%0d", ln, c), bclk_w[ln], ((c / 8) % 2) == 1);
    end
  endtask

  task automatic run_to(input int n);
    while (c < n) tick();
  endtask

  task automatic reset_checks(input string tag);
    bit idle[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int ln = 0; ln < 4; ln++) begin
      chk($sformatf("%s_bclk%0d", tag, ln), bclk_w[ln], 1'b0);
      chk($sformatf("%s_sdata%0d", tag, ln), sd_w[ln], 1'b0);
      chk($sformatf("%s_ready%0d", tag, ln), rdy_w[ln], 1'b1);
      chk($sformatf("%s_underrun%0d", tag, ln), und_w[ln], 1'b0);
      chk($sformatf("%s_lrclk%0d", tag, ln), lr_w[ln], idle[ln]);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    c = 0; pfull = 1'b0; first_m = 1'b1; last_s = '0; last_t = '0;
    frames_s.delete(); frames_t.delete(); vols.delete(); zq.delete();
    for (int ln = 0; ln < 4; ln++) begin q_d[ln].delete(); q_l[ln].delete(); end
  endtask

  task automatic check_streams(input int nexp);
    for (int ln = 0; ln < 4; ln++) begin
      int sw, dly, nf, nchk;
      logic [31:0] got_d, exp_d, got_l, exp_l;
      sw  = (ln < 2) ? 32 : 16;
      dly = (ln == 1 || ln == 3) ? 1 : 0;
      nf  = (q_d[ln].size() >= 2) ? (q_d[ln].size() - 2) / 64 : 0;
      if (nf > frames_s.size()) nf = frames_s.size();
      chk($sformatf("frames_seen%0d", ln), 64'(nf >= nexp), 64'(1));
      nchk = (nf < nexp) ? nf : nexp;
      for (int k = 0; k < nchk; k++) begin
        for (int s = 0; s < 64 / sw; s++) begin
          got_d = '0; exp_d = '0; got_l = '0; exp_l = '0;
          for (int b = 0; b < sw; b++) begin
            int i;
            i     = k * 64 + s * sw + b;
            got_d = {got_d[30:0], q_d[ln][i + dly + 1]};
            exp_d = {exp_d[30:0], lj_bit(ln, i)};
            got_l = {got_l[30:0], q_l[ln][i + 1]};
            exp_l = {exp_l[30:0], lr_exp(ln, i)};
          end
          chk($sformatf("data%0d_f%0d_s%0d", ln, k, s), got_d, exp_d);
          chk($sformatf("lrclk%0d_f%0d_s%0d", ln, k, s), got_l, exp_l);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] x2s, x3s;
    logic [63:0] x2t, x3t;
    x2s = $urandom();
    x3s = $urandom();
    x2t = {$urandom(), $urandom()};
    x2t[15:0] = 16'h8000;
    x3t = {$urandom(), $urandom()};

    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    release_reset();

    // two sets back to back: second waits for the next load fall
    run_to(99);
    valid_v = 1'b1; sd = 32'h0001_A5C3; td = 64'h4444_3333_2222_1111;
    tick();
    sd = x2s; td = x2t;
    run_to(1044);
    valid_v = 1'b0;
`ifdef JTFRAME_I2S_VOL_EN
    run_to(2000);
    vol_v = 4'd4;
    run_to(2100);
    vol_v = 4'd0;
`endif
    // valid only on the load fall with pending empty: bypass
    run_to(3087);
    valid_v = 1'b1; sd = x3s; td = x3t;
    tick();
    valid_v = 1'b0;
    run_to(6169);
    valid_v = 1'b1; sd = $urandom(); td = {$urandom(), $urandom()};
    tick();
    valid_v = 1'b0;
    run_to(6200);
    check_streams(6);
`ifdef JTFRAME_I2S_VOL_EN
    begin
      logic [15:0] w;
      w = '0;
      for (int b = 0; b < 16; b++) w = {w[14:0], q_d[2][1 + 2 * 64 + b]};
      chk("vol4_8000", w, 16'hF800);
    end
`endif

    // mid-frame reset with a pending sample held
    chk("pending_before_reset", rdy_w[0], 1'b0);
    rst = 1'b1;
    #1;
    reset_checks("async");
    repeat (5) @(posedge clk);
    #1;
    reset_checks("held");
    release_reset();
    run_to(2200);
    check_streams(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
